// File: rtl/fpu_sqrt_arbiter.sv
// rtl/fpu_sqrt_arbiter.sv - round-robin sharing of one pipelined FP sqrt unit
//
// Purpose: arbitrates NUM_REQS requesters into a one-entry issue register that
// feeds a shared sqrt unit, tags each operation with its requester index, and
// bounds the number of in-flight operations. Responses are steered back
// combinationally by the index carried in the returned tag.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             per-requester request handshake
//   req_data/req_frm/req_tag        per-requester operand, rounding mode, tag
//   unit_valid_in/unit_ready_in     issue handshake to the shared unit
//   unit_data/unit_frm/unit_tag     issued operand, rounding mode, {index, tag}
//   unit_valid_out/unit_ready_out   result handshake from the shared unit
//   unit_result/unit_fflags         result and exception flags
//   unit_tag_out                    returned {index, tag}
//   rsp_valid/rsp_ready             per-requester response handshake
//   rsp_result/rsp_fflags/rsp_tag   shared response buses
//   pending_count                   operations issued and not yet returned

module fpu_sqrt_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int TAG_WIDTH    = 8,
    parameter int MAX_PENDING  = 8,
    parameter int REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int UTAG_W      = REQ_SEL_BITS + TAG_WIDTH,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS-1:0]                 req_valid,
    output logic [NUM_REQS-1:0]                 req_ready,
    input  logic [NUM_REQS-1:0][31:0]           req_data,
    input  logic [NUM_REQS-1:0][2:0]            req_frm,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag,
    output logic                                unit_valid_in,
    input  logic                                unit_ready_in,
    output logic [31:0]                         unit_data,
    output logic [2:0]                          unit_frm,
    output logic [UTAG_W-1:0]                   unit_tag,
    input  logic                                unit_valid_out,
    output logic                                unit_ready_out,
    input  logic [31:0]                         unit_result,
    input  logic [4:0]                          unit_fflags,
    input  logic [UTAG_W-1:0]                   unit_tag_out,
    output logic [NUM_REQS-1:0]                 rsp_valid,
    input  logic [NUM_REQS-1:0]                 rsp_ready,
    output logic [31:0]                         rsp_result,
    output logic [4:0]                          rsp_fflags,
    output logic [TAG_WIDTH-1:0]                rsp_tag,
    output logic [CNT_W-1:0]                    pending_count
);

    localparam logic [CNT_W:0] MAX_P = (CNT_W + 1)'(MAX_PENDING);

    // Issue register
    logic                     valid_q, valid_d;
    logic [REQ_SEL_BITS-1:0]  idx_q, idx_d;
    logic [31:0]              data_q, data_d;
    logic [2:0]               frm_q, frm_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;

    logic [REQ_SEL_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         pending_q, pending_d;

    logic                     fire;
    logic                     load_ok;
    logic                     load;
    logic [CNT_W:0]           occupancy;
    logic                     grant_found;
    logic [REQ_SEL_BITS-1:0]  grant_idx;
    logic [REQ_SEL_BITS-1:0]  cand;

    logic [REQ_SEL_BITS-1:0]  rsp_idx;
    logic                     rsp_fire;
    logic                     dec;

    assign fire = valid_q & unit_ready_in;

    // The occupied register counts against the limit even while it fires: the
    // firing operation moves into pending_count on the same edge, so the sum
    // pending + occupied never exceeds MAX_PENDING after the load.
    assign occupancy = {1'b0, pending_q} + {{CNT_W{1'b0}}, valid_q};
    assign load_ok   = (~valid_q | fire) & (occupancy < MAX_P);

    // Round-robin scan starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = REQ_SEL_BITS'((int'(rr_ptr_q) + k) % NUM_REQS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign load = load_ok & grant_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = load && (grant_idx == REQ_SEL_BITS'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQS - 1) ? '0
                                                         : grant_idx + REQ_SEL_BITS'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        frm_d   = frm_q;
        tag_d   = tag_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = grant_idx;
            data_d  = req_data[grant_idx];
            frm_d   = req_frm[grant_idx];
            tag_d   = req_tag[grant_idx];
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    // Response steering; an out-of-range index is drained with ready held high
    assign rsp_idx = unit_tag_out[UTAG_W-1 -: REQ_SEL_BITS];

    always_comb begin
        rsp_valid      = '0;
        unit_ready_out = 1'b1;
        for (int j = 0; j < NUM_REQS; j++) begin
            if (rsp_idx == REQ_SEL_BITS'(j)) begin
                rsp_valid[j]   = unit_valid_out;
                unit_ready_out = rsp_ready[j];
            end
        end
    end

    assign rsp_fire = unit_valid_out & unit_ready_out;
    // Responses that outlive a reset still drain but must not wrap the counter
    assign dec      = rsp_fire & (pending_q != '0);

    always_comb begin
        pending_d = pending_q;
        if (fire && !dec) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (dec && !fire) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            frm_q     <= '0;
            tag_q     <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            frm_q     <= frm_d;
            tag_q     <= tag_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

    assign unit_valid_in = valid_q;
    assign unit_data     = data_q;
    assign unit_frm      = frm_q;
    assign unit_tag      = {idx_q, tag_q};
    assign rsp_result    = unit_result;
    assign rsp_fflags    = unit_fflags;
    assign rsp_tag       = unit_tag_out[TAG_WIDTH-1:0];
    assign pending_count = pending_q;

    a_rsp_idx_legal: assert property (@(posedge clk) disable iff (reset)
        unit_valid_out |-> (int'(rsp_idx) < NUM_REQS));

endmodule

// File: tb/tb_fpu_sqrt_arbiter.sv
// tb/tb_fpu_sqrt_arbiter.sv - self-checking bench for fpu_sqrt_arbiter
module tb_fpu_sqrt_arbiter;
    localparam int N  = 4;
    localparam int TW = 8;
    localparam int MP = 8;
    localparam int SB = 2;
    localparam int UW = SB + TW;
    localparam int CW = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][31:0]     req_data;
    logic [N-1:0][2:0]      req_frm;
    logic [N-1:0][TW-1:0]   req_tag;
    logic                   unit_valid_in;
    logic                   unit_ready_in;
    logic [31:0]            unit_data;
    logic [2:0]             unit_frm;
    logic [UW-1:0]          unit_tag;
    logic                   unit_valid_out;
    logic                   unit_ready_out;
    logic [31:0]            unit_result;
    logic [4:0]             unit_fflags;
    logic [UW-1:0]          unit_tag_out;
    logic [N-1:0]           rsp_valid;
    logic [N-1:0]           rsp_ready;
    logic [31:0]            rsp_result;
    logic [4:0]             rsp_fflags;
    logic [TW-1:0]          rsp_tag;
    logic [CW-1:0]          pending_count;

    always #5 clk = ~clk;

    fpu_sqrt_arbiter #(.NUM_REQS(N), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_frm(req_frm), .req_tag(req_tag),
        .unit_valid_in(unit_valid_in), .unit_ready_in(unit_ready_in),
        .unit_data(unit_data), .unit_frm(unit_frm), .unit_tag(unit_tag),
        .unit_valid_out(unit_valid_out), .unit_ready_out(unit_ready_out),
        .unit_result(unit_result), .unit_fflags(unit_fflags), .unit_tag_out(unit_tag_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_fflags(rsp_fflags), .rsp_tag(rsp_tag), .pending_count(pending_count)
    );

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [2:0]  frm;
        logic [7:0]  tag;
        logic [31:0] result;
        logic [4:0]  flags;
        logic [3:0]  exp_onehot;
        logic [9:0]  exp_utag;
    } vec_t;

    typedef struct packed {
        logic [9:0]  utag;
        logic [31:0] data;
        logic [2:0]  frm;
    } iss_t;

    vec_t vecs[4];
    iss_t sb[$];
    iss_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt[N];
    int   acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted requests are queued, issues are checked in order
    always @(negedge clk) begin
        if (!reset) begin
            if (unit_valid_in && unit_ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("issue_payload", {unit_tag, unit_data, unit_frm}, mon_e);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({SB'(i), req_tag[i], req_data[i], req_frm[i]});
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = '0;
        unit_valid_out = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{2, 32'h40800000, 3'd0, 8'h05, 32'h40000000, 5'h00, 4'b0100, 10'h205};
        vecs[1] = '{0, 32'h41100000, 3'd1, 8'hA5, 32'h40400000, 5'h00, 4'b0001, 10'h0A5};
        vecs[2] = '{3, 32'h3F800000, 3'd4, 8'hFF, 32'h3F800000, 5'h00, 4'b1000, 10'h3FF};
        vecs[3] = '{1, 32'hBF800000, 3'd2, 8'h00, 32'h7FC00000, 5'h10, 4'b0010, 10'h100};

        req_valid = '0; req_data = '0; req_frm = '0; req_tag = '0;
        unit_ready_in = 1'b0; unit_valid_out = 1'b0; unit_result = '0;
        unit_fflags = '0; unit_tag_out = '0; rsp_ready = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_unit_valid_in", unit_valid_in, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_req_ready", req_ready, 0);
        reset = 1'b0;
        #1 req_valid = '1;
        #1 chk("rst_first_grant", req_ready, 4'b0001);
        req_valid = '0;

        // Single-op round trips from the vector table
        for (int v = 0; v < 4; v++) begin
            @(posedge clk);
            #1;
            req_valid = '0;
            req_valid[vecs[v].idx] = 1'b1;
            req_data[vecs[v].idx]  = vecs[v].data;
            req_frm[vecs[v].idx]   = vecs[v].frm;
            req_tag[vecs[v].idx]   = vecs[v].tag;
            unit_ready_in = 1'b1;
            rsp_ready = '1;
            #1;
            chk("vec_req_ready", req_ready, vecs[v].exp_onehot);
            chk("vec_pending_before", pending_count, 0);
            @(posedge clk);
            #1 req_valid = '0;
            #1;
            chk("vec_unit_valid_in", unit_valid_in, 1);
            chk("vec_unit_tag", unit_tag, vecs[v].exp_utag);
            chk("vec_unit_data", unit_data, vecs[v].data);
            chk("vec_unit_frm", unit_frm, vecs[v].frm);
            @(posedge clk);
            #1;
            chk("vec_pending_issued", pending_count, 1);
            chk("vec_reg_empty", unit_valid_in, 0);
            unit_valid_out = 1'b1;
            unit_result    = vecs[v].result;
            unit_fflags    = vecs[v].flags;
            unit_tag_out   = vecs[v].exp_utag;
            #1;
            chk("vec_rsp_valid", rsp_valid, vecs[v].exp_onehot);
            chk("vec_rsp_tag", rsp_tag, vecs[v].tag);
            chk("vec_rsp_result", rsp_result, vecs[v].result);
            chk("vec_rsp_fflags", rsp_fflags, vecs[v].flags);
            chk("vec_unit_ready_out", unit_ready_out, 1);
            @(posedge clk);
            #1 unit_valid_out = 1'b0;
            #1 chk("vec_pending_after", pending_count, 0);
        end

        // Fairness: all requesters valid, responses draining every cycle
        do_reset();
        unit_ready_in = 1'b1;
        unit_valid_out = 1'b1;
        unit_tag_out = 10'h000;
        rsp_ready = '1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            req_tag[i] = TW'(8'h10 + i);
            req_frm[i] = 3'(i);
        end
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < N; i++) req_data[i] = $urandom;
            #1;
            chk("fair_grant", req_ready, 4'b0001 << (k % 4));
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 25);
        req_valid = '0;
        unit_valid_out = 1'b0;

        // Pending limit with no responses
        do_reset();
        req_valid = '1;
        unit_ready_in = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) acc++;
            @(posedge clk);
            #1;
        end
        chk("maxp_accepted", acc, 8);
        chk("maxp_pending", pending_count, 8);
        chk("maxp_req_ready", req_ready, 0);
        chk("maxp_reg_empty", unit_valid_in, 0);
        unit_valid_out = 1'b1;
        unit_tag_out = 10'h300;
        #1;
        chk("maxp_ready_indep_rsp", req_ready, 0);
        chk("maxp_unit_ready_out", unit_ready_out, 1);
        @(posedge clk);
        #1 unit_valid_out = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) acc++;
            @(posedge clk);
            #1;
        end
        chk("maxp_one_more", acc, 1);
        chk("maxp_pending_final", pending_count, 8);
        req_valid = '0;

        // Issue stall holds payload and blocks requesters
        do_reset();
        unit_ready_in = 1'b0;
        req_valid = 4'b0010;
        req_data[1] = 32'h3F000000;
        req_frm[1] = 3'd3;
        req_tag[1] = 8'h3C;
        @(posedge clk);
        #1;
        req_valid = 4'b1011;
        req_data[1] = 32'hDEADBEEF;
        req_tag[1] = 8'h99;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_req_ready", req_ready, 0);
            chk("stall_payload", {unit_tag, unit_data, unit_frm}, {10'h13C, 32'h3F000000, 3'd3});
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        unit_ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_released", unit_valid_in, 0);
        chk("stall_pending", pending_count, 1);

        // Response backpressure, then simultaneous issue and response
        do_reset();
        unit_ready_in = 1'b1;
        rsp_ready = '1;
        req_valid = 4'b0010;
        req_tag[1] = 8'h11;
        req_data[1] = 32'h40800000;
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        req_tag[2] = 8'h22;
        req_data[2] = 32'h41800000;
        @(posedge clk);
        #1;
        req_valid = '0;
        unit_ready_in = 1'b0;
        unit_valid_out = 1'b1;
        unit_tag_out = 10'h111;
        rsp_ready = 4'b1101;
        #1;
        chk("bp_unit_ready_out", unit_ready_out, 0);
        chk("bp_rsp_valid", rsp_valid, 4'b0010);
        chk("bp_rsp_tag", rsp_tag, 8'h11);
        chk("bp_pending", pending_count, 1);
        @(posedge clk);
        #1;
        chk("bp_pending_hold", pending_count, 1);
        chk("bp_reg_full", unit_valid_in, 1);
        rsp_ready = '1;
        unit_ready_in = 1'b1;
        #1 chk("bp_unit_ready_out_hi", unit_ready_out, 1);
        @(posedge clk);
        #1 unit_valid_out = 1'b0;
        chk("bp_pending_simul", pending_count, 1);
        chk("bp_reg_drained", unit_valid_in, 0);

        // Asynchronous reset with ops pending and the register full
        do_reset();
        unit_ready_in = 1'b1;
        req_valid = '1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        chk("ar_pre_pending", pending_count, 3);
        chk("ar_pre_reg_full", unit_valid_in, 1);
        unit_ready_in = 1'b0;
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        chk("ar_unit_valid_in", unit_valid_in, 0);
        chk("ar_pending", pending_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        req_valid = '1;
        unit_ready_in = 1'b1;
        #1 chk("ar_rr_ptr", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        chk("ar_sb_drained", sb.size(), 0);
        chk("ar_reg_empty", unit_valid_in, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
